// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light lamp monitor:
// phase and monitor-state enums, error codes, legal successor lookup.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_ONEHOT    = 3'd1;
    localparam logic [2:0] ERR_BAD_TRANS = 3'd2;
    localparam logic [2:0] ERR_SHORT     = 3'd3;
    localparam logic [2:0] ERR_LONG      = 3'd4;

    function automatic phase_t legal_next(input phase_t p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, load-to-one and increment.
// Clear beats load, load beats increment; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(1);
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence checker: decodes phase, tracks dwell,
// checks RED->GREEN->YELLOW->RED ordering and dwell limits.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int RED_T    = 4,
    parameter int GREEN_T  = 4,
    parameter int YELLOW_T = 2,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          red,
    input  logic          yellow,
    input  logic          green,
    input  logic          err_clr,
    output logic [1:0]    phase,
    output logic [DW-1:0] dwell,
    output logic [15:0]   cycles,
    output logic          err,
    output logic [2:0]    err_code,
    output logic          err_pulse
);

    localparam logic [DW-1:0] L_RED    = DW'(RED_T);
    localparam logic [DW-1:0] L_GREEN  = DW'(GREEN_T);
    localparam logic [DW-1:0] L_YELLOW = DW'(YELLOW_T);

    mon_state_t    r_state;
    mon_state_t    w_state_nxt;
    phase_t        r_phase;
    phase_t        w_phase;
    logic [DW-1:0] w_dwell;
    logic [DW-1:0] w_limit;
    logic [15:0]   r_cycles;
    logic          r_err;
    logic [2:0]    r_err_code;
    logic          r_err_pulse;
    logic [2:0]    w_code;
    logic          w_track;
    logic          w_same;
    logic          w_change;
    logic          w_legal;
    logic          w_cycle_inc;

    always_comb begin
        case ({red, green, yellow})
            3'b100:  w_phase = PH_RED;
            3'b010:  w_phase = PH_GREEN;
            3'b001:  w_phase = PH_YELLOW;
            default: w_phase = PH_NONE;
        endcase
    end

    always_comb begin
        case (r_phase)
            PH_RED:    w_limit = L_RED;
            PH_GREEN:  w_limit = L_GREEN;
            PH_YELLOW: w_limit = L_YELLOW;
            default:   w_limit = '0;
        endcase
    end

    assign w_track  = (r_state == ST_TRACK);
    assign w_same   = (w_phase != PH_NONE) && (w_phase == r_phase);
    assign w_change = (w_phase != PH_NONE) && (r_phase != PH_NONE)
                   && (w_phase != r_phase);
    assign w_legal  = w_change && (w_phase == legal_next(r_phase));

    // Only the highest-priority event on a sample is reported.
    always_comb begin
        w_code      = ERR_NONE;
        w_state_nxt = r_state;
        if (w_phase == PH_NONE) begin
            w_code = ERR_ONEHOT;
        end else if (w_track && w_change && !w_legal) begin
            w_code = ERR_BAD_TRANS;
        end else if (w_track && w_legal && (w_dwell < w_limit)) begin
            w_code = ERR_SHORT;
        end else if (w_track && w_same && (w_dwell == w_limit)) begin
            w_code = ERR_LONG;
        end
        if (w_code != ERR_NONE) begin
            w_state_nxt = ST_SYNC;
        end else if (!w_track && w_legal) begin
            w_state_nxt = ST_TRACK;
        end
    end

    assign w_cycle_inc = w_track && w_legal && (r_phase == PH_YELLOW)
                      && (w_code == ERR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    sat_counter #(
        .W (DW)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_phase == PH_NONE),
        .i_load  (!w_same),
        .i_inc   (w_same),
        .o_count (w_dwell)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH_NONE;
            r_cycles    <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_pulse <= 1'b0;
        end else begin
            r_phase     <= w_phase;
            r_err_pulse <= (w_code != ERR_NONE);
            if (w_cycle_inc) begin
                r_cycles <= r_cycles + 16'd1;
            end
            if (w_code != ERR_NONE) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign phase     = r_phase;
    assign dwell     = w_dwell;
    assign cycles    = r_cycles;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_pulse = r_err_pulse;

endmodule
